// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the execute-stage ALU.
// Supports hazard-unit stall (hold with operand re-capture) and flush (bubble).
module ex_operand_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stall,
  input  logic          i_flush,
  input  logic          i_id_valid,
  input  logic [DW-1:0] i_id_rd1,
  input  logic [DW-1:0] i_id_rd2,
  input  logic [AW-1:0] i_id_rs,
  input  logic [AW-1:0] i_id_rt,
  input  logic [AW-1:0] i_id_rd,
  input  logic [DW-1:0] i_id_imm,
  input  logic          i_id_alusrc,
  input  logic          i_id_regdst,
  input  logic          i_id_regwrite,
  input  logic [2:0]    i_id_alucontrol,
  input  logic          i_mem_regwrite,
  input  logic [AW-1:0] i_mem_dst,
  input  logic [DW-1:0] i_mem_result,
  input  logic          i_wb_regwrite,
  input  logic [AW-1:0] i_wb_dst,
  input  logic [DW-1:0] i_wb_result,
  output logic [DW-1:0] o_SrcA,
  output logic [DW-1:0] o_SrcB,
  output logic [2:0]    o_ALUControl,
  output logic          o_ex_valid,
  output logic          o_ex_regwrite,
  output logic [AW-1:0] o_ex_dst,
  output logic [DW-1:0] o_ex_wdata,
  output logic [1:0]    o_fwd_a,
  output logic [1:0]    o_fwd_b
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] imm;
    logic          alusrc;
    logic          regdst;
    logic          regwrite;
    logic [2:0]    alucontrol;
  } stage_t;

  stage_t        stage_q, stage_d;
  logic [DW-1:0] fwd_a_val, fwd_b_val;
  logic [1:0]    fwd_a_sel, fwd_b_sel;

  // MEM is checked last so it overrides WB when both match (newer value).
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_a_val = stage_q.opa;
    if (i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == stage_q.rs)) begin
      fwd_a_sel = 2'd1;
      fwd_a_val = i_wb_result;
    end
    if (i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == stage_q.rs)) begin
      fwd_a_sel = 2'd2;
      fwd_a_val = i_mem_result;
    end

    fwd_b_sel = 2'd0;
    fwd_b_val = stage_q.opb;
    if (i_wb_regwrite && (i_wb_dst != '0) && (i_wb_dst == stage_q.rt)) begin
      fwd_b_sel = 2'd1;
      fwd_b_val = i_wb_result;
    end
    if (i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == stage_q.rt)) begin
      fwd_b_sel = 2'd2;
      fwd_b_val = i_mem_result;
    end
  end

  // A stall re-captures the forwarded operands so a WB value survives retirement.
  always_comb begin
    stage_d = stage_q;
    if (i_flush) begin
      stage_d = '0;
    end else if (i_stall) begin
      stage_d.opa = fwd_a_val;
      stage_d.opb = fwd_b_val;
    end else begin
      stage_d.valid      = i_id_valid;
      stage_d.opa        = i_id_rd1;
      stage_d.opb        = i_id_rd2;
      stage_d.rs         = i_id_rs;
      stage_d.rt         = i_id_rt;
      stage_d.rd         = i_id_rd;
      stage_d.imm        = i_id_imm;
      stage_d.alusrc     = i_id_alusrc;
      stage_d.regdst     = i_id_regdst;
      stage_d.regwrite   = i_id_regwrite & i_id_valid;
      stage_d.alucontrol = i_id_alucontrol;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  always_comb begin
    o_SrcA        = fwd_a_val;
    o_SrcB        = stage_q.alusrc ? stage_q.imm : fwd_b_val;
    o_ex_wdata    = fwd_b_val;
    o_ex_dst      = stage_q.regdst ? stage_q.rd : stage_q.rt;
    o_ex_regwrite = stage_q.regwrite & stage_q.valid;
    o_ex_valid    = stage_q.valid;
    o_ALUControl  = stage_q.alucontrol;
    o_fwd_a       = fwd_a_sel;
    o_fwd_b       = fwd_b_sel;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register plus operand-forwarding network that directly feeds the execute-stage ALU. It latches decoded operands and control from the decode stage each cycle. It then resolves read-after-write hazards against the in-flight MEM and WB results and drives the ALU's `SrcA`, `SrcB` and `ALUControl` inputs. It supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
Parameters:
- `DW`, default 32: datapath width.
- `AW`, default 5: register-index width.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` input 1: clock; all state updates on rising edge.
- `i_rst` input 1: synchronous active-high reset.
- `i_stall` input 1: hold the stage contents this cycle.
- `i_flush` input 1: load a bubble this cycle.
- `i_id_valid` input 1: the decode slot holds a real instruction.
- `i_id_rd1`, `i_id_rd2` input DW: register-file read data for rs and rt.
- `i_id_rs`, `i_id_rt`, `i_id_rd` input AW: register indices.
- `i_id_imm` input DW: sign-extended immediate.
- `i_id_alusrc` input 1: 1 selects the immediate for SrcB.
- `i_id_regdst` input 1: 1 selects rd as the destination, 0 selects rt.
- `i_id_regwrite` input 1: the instruction writes the register file.
- `i_id_alucontrol` input 3: ALU operation code.
- `i_mem_regwrite` input 1, `i_mem_dst` input AW, `i_mem_result` input DW: MEM-stage writeback candidate.
- `i_wb_regwrite` input 1, `i_wb_dst` input AW, `i_wb_result` input DW: WB-stage writeback candidate.
- `o_SrcA`, `o_SrcB` output DW: ALU operands.
- `o_ALUControl` output 3: ALU operation.
- `o_ex_valid` output 1: the stage holds a real instruction.
- `o_ex_regwrite` output 1: gated by valid.
- `o_ex_dst` output AW: destination register.
- `o_ex_wdata` output DW: store data, which is the forwarded rt value.
- `o_fwd_a`, `o_fwd_b` output 2: forward select; 0 = register file, 1 = WB, 2 = MEM.

## Operation
- Registered fields: valid, opA (DW), opB (DW), rs, rt, rd, imm, alusrc, regdst, regwrite, alucontrol.
- Update priority each edge:
  - `i_rst`: clear all fields.
  - else `i_flush`: load a bubble (all fields zero).
  - else `i_stall`: hold, with the operand re-capture described below.
  - else: load from the `i_id_*` inputs; `regwrite` stored as `i_id_regwrite & i_id_valid`.
- Forwarding is combinational on the registered rs/rt:
  - The MEM source matches when `i_mem_regwrite` is set, `i_mem_dst != 0` and `i_mem_dst == rs`.
  - The WB source matches under the same conditions using the `i_wb_*` ports.
  - If both match, MEM has priority because it holds the newer value.
  - Register 0 is never forwarded, so `$zero` stays zero.
  - `o_fwd_b` is evaluated the same way against rt.
- `fwdA` = selected value for rs; `fwdB` = selected value for rt.
- `o_SrcA = fwdA`; `o_SrcB = alusrc ? imm : fwdB`; `o_ex_wdata = fwdB`.
- `o_ex_dst = regdst ? rd : rt`.
- `o_ex_regwrite = regwrite & valid`; `o_ALUControl = alucontrol`.
- Stall re-capture: while `i_stall` is set (without reset or flush), opA ← fwdA and opB ← fwdB. This keeps a value forwarded from WB from being lost when that instruction retires during the stall. The capture is idempotent: the same writer still in the pipeline forwards the same value.
- Bubble outputs: valid = 0, regwrite = 0, SrcA/SrcB = 0, dst = 0.

## Timing
- Reset: every output is 0 on the first edge with `i_rst` = 1, including `o_fwd_a` and `o_fwd_b`, because rs = rt = 0 disables forwarding.
- Latency: decode inputs appear on the outputs one cycle after the capture edge.
- Forwarded values track the MEM/WB inputs within the same cycle (zero latency).
- Flush and stall asserted together: flush wins.
- Reset and flush or stall together: reset wins.
- A stall inserted back-to-back with a flush holds the bubble.
- Reset mid-stall: contents are discarded and the stage restarts empty.
- Width: all datapaths are DW bits; there is no arithmetic in this block.
- `i_id_valid` = 0 with no stall loads a bubble-equivalent: operands are captured but regwrite is forced to 0 and valid is 0.

## Test plan
- **Reset:** hold `i_rst` for 2 cycles with random inputs → all outputs 0, `o_ex_valid` = 0.
- **Plain load:** rd1 = 0x11, rd2 = 0x22, rs = 3, rt = 4, rd = 5, regdst = 1, alusrc = 0, no forwarding → next cycle SrcA = 0x11, SrcB = 0x22, dst = 5, fwd = 0/0.
- **Forward priority:** stage holds rs = 7. MEM dst = 7 with 0xAAAA and WB dst = 7 with 0xBBBB → SrcA = 0xAAAA, `o_fwd_a` = 2. Drop `i_mem_regwrite` → SrcA = 0xBBBB, `o_fwd_a` = 1.
- **Zero register:** rs = 0 with MEM dst = 0, regwrite = 1, result 0xDEAD → SrcA = stored rd1 (0), `o_fwd_a` = 0.
- **Stall capture:** WB forwards 0x1234 to rt during a 1-cycle stall. Next cycle WB moves on (regwrite = 0) → SrcB still 0x1234. The stage does not advance while stalled.
- **Flush vs stall:** assert both with a valid decode input → next cycle valid = 0, regwrite = 0, SrcA = SrcB = 0. Immediate path: alusrc = 1, imm = 0xFFFFFFFC → SrcB = 0xFFFFFFFC and `o_ex_wdata` = forwarded rt value.
